// File: rtl/rr_arbiter_4.sv
// rr_arbiter_4: 4-way round-robin arbiter with hold limit; ports clk, rst_n (async low), req[3:0], done in; gnt_idx[1:0], gnt_vld, timeout out
module rr_arbiter_4 #(
  parameter int MAX_HOLD = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] req,
  input  logic       done,
  output logic [1:0] gnt_idx,
  output logic       gnt_vld,
  output logic       timeout
);
  typedef enum logic {IDLE, GRANT} state_t;
  state_t     state, state_nx;
  logic [1:0] ptr, ptr_nx, pick, idx_nx;
  logic [7:0] hold_cnt, cnt_nx;
  logic       hit, lim, rel, to_nx;
  always_comb begin
    pick = ptr;
    for (int k = 3; k >= 0; k--)
      if (req[ptr + 2'(k)]) pick = ptr + 2'(k);
    hit = req[gnt_idx];
    lim = hold_cnt == 8'(MAX_HOLD - 1);
    rel = done | ~hit | lim;
    state_nx = state == IDLE ? (|req ? GRANT : IDLE) : (rel ? IDLE : GRANT);
    idx_nx = state == IDLE && |req ? pick : gnt_idx;
    ptr_nx = state == GRANT && rel ? gnt_idx + 2'd1 : ptr;
    cnt_nx = state == IDLE || rel ? 8'd0 : hold_cnt + 8'd1;
    to_nx = state == GRANT && lim && !done && hit;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state    <= IDLE;
      ptr      <= 2'd0;
      hold_cnt <= 8'd0;
      gnt_idx  <= 2'd0;
      timeout  <= 1'b0;
    end else begin
      state    <= state_nx;
      ptr      <= ptr_nx;
      hold_cnt <= cnt_nx;
      gnt_idx  <= idx_nx;
      timeout  <= to_nx;
    end
  assign gnt_vld = state == GRANT;
endmodule

// File: tb/tb_rr_arbiter_4.sv
// tb_rr_arbiter_4: directed vector bench for rr_arbiter_4 with MAX_HOLD = 4
module tb_rr_arbiter_4;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [3:0] req = 4'b0000;
  logic       done = 1'b0;
  logic [1:0] gnt_idx;
  logic       gnt_vld, timeout;
  int         checks = 0, errors = 0;
  typedef struct {
    logic [3:0] req;
    logic       done;
    logic [1:0] idx;
    logic       vld;
    logic       to;
  } vec_t;
  vec_t tv[$];
  rr_arbiter_4 #(.MAX_HOLD(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .done(done),
    .gnt_idx(gnt_idx), .gnt_vld(gnt_vld), .timeout(timeout)
  );
  always #5 clk = ~clk;
  function automatic vec_t v(logic [3:0] r, logic d, logic [1:0] i, logic g, logic t);
    vec_t x;
    x.req = r;
    x.done = d;
    x.idx = i;
    x.vld = g;
    x.to = t;
    return x;
  endfunction
  task automatic chk(string name, logic [1:0] i, logic g, logic t);
    checks++;
    if ({gnt_idx, gnt_vld, timeout} !== {i, g, t}) begin
      errors++;
      $display("FAIL %s: got idx=%0d vld=%b to=%b, want idx=%0d vld=%b to=%b",
               name, gnt_idx, gnt_vld, timeout, i, g, t);
    end
  endtask
  initial begin
    tv.push_back(v(4'b1111, 0, 0, 1, 0));
    tv.push_back(v(4'b1111, 1, 0, 0, 0));
    tv.push_back(v(4'b1111, 0, 1, 1, 0));
    tv.push_back(v(4'b1111, 1, 1, 0, 0));
    tv.push_back(v(4'b1111, 0, 2, 1, 0));
    tv.push_back(v(4'b1111, 1, 2, 0, 0));
    tv.push_back(v(4'b1111, 0, 3, 1, 0));
    tv.push_back(v(4'b1111, 1, 3, 0, 0));
    tv.push_back(v(4'b1111, 0, 0, 1, 0));
    tv.push_back(v(4'b1111, 1, 0, 0, 0));
    tv.push_back(v(4'b0000, 1, 0, 0, 0));
    tv.push_back(v(4'b0100, 0, 2, 1, 0));
    tv.push_back(v(4'b0100, 0, 2, 1, 0));
    tv.push_back(v(4'b0100, 0, 2, 1, 0));
    tv.push_back(v(4'b0100, 0, 2, 1, 0));
    tv.push_back(v(4'b0100, 1, 2, 0, 0));
    tv.push_back(v(4'b0100, 0, 2, 1, 0));
    tv.push_back(v(4'b0000, 0, 2, 0, 0));
    tv.push_back(v(4'b1001, 0, 3, 1, 0));
    tv.push_back(v(4'b1001, 1, 3, 0, 0));
    tv.push_back(v(4'b1001, 0, 0, 1, 0));
    tv.push_back(v(4'b1001, 1, 0, 0, 0));
    tv.push_back(v(4'b0010, 0, 1, 1, 0));
    tv.push_back(v(4'b0011, 0, 1, 1, 0));
    tv.push_back(v(4'b0011, 0, 1, 1, 0));
    tv.push_back(v(4'b0011, 0, 1, 1, 0));
    tv.push_back(v(4'b0010, 0, 1, 0, 1));
    tv.push_back(v(4'b0010, 0, 1, 1, 0));
    tv.push_back(v(4'b0000, 0, 1, 0, 0));
    #3 chk("reset", 0, 0, 0);
    #4 rst_n = 1'b1;
    foreach (tv[n]) begin
      req = tv[n].req;
      done = tv[n].done;
      @(posedge clk);
      #1 chk($sformatf("vec%0d", n), tv[n].idx, tv[n].vld, tv[n].to);
    end
    req = 4'b1111;
    done = 1'b0;
    @(posedge clk);
    #1 chk("pre_rst_grant", 2, 1, 0);
    #2 rst_n = 1'b0;
    #1 chk("async_rst", 0, 0, 0);
    @(posedge clk);
    #1 chk("held_rst", 0, 0, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1 chk("post_rst_grant", 0, 1, 0);
    done = 1'b1;
    @(posedge clk);
    #1 chk("post_rst_rel", 0, 0, 0);
    done = 1'b0;
    @(posedge clk);
    #1 chk("post_rst_next", 1, 1, 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
